// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: Moore FSM sequencing a MIPS instruction over 3-5 cycles.
// Ports: clk, rst_n (async, active low); Instruction_op (opcode), MemReady (memory done);
// datapath strobes PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
// RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc; IllegalOp pulse; State for debug.
module multicycle_control_unit #(
  parameter bit MEM_WAIT = 1'b1,
  parameter bit ENABLE_ADDI = 1'b1,
  parameter bit ENABLE_JUMP = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Instruction_op,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       IllegalOp,
  output logic [3:0] State
);
  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTE, ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ILLEGAL
  } state_t;
  state_t state, nextState;
  logic rdy;
  assign rdy = MemReady | ~MEM_WAIT;
  assign State = state;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nextState;
  always_comb begin
    PCWrite = 1'b0;
    Branch = 1'b0;
    IorD = 1'b0;
    MemRead = 1'b0;
    MemWrite = 1'b0;
    IRWrite = 1'b0;
    MemtoReg = 1'b0;
    RegDst = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA = 1'b0;
    ALUSrcB = 2'b00;
    ALUOp = 2'b00;
    PCSrc = 2'b00;
    IllegalOp = 1'b0;
    nextState = IDLE;
    case (state)
      IDLE: nextState = FETCH;
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // the instruction latch and PC+4 only commit once memory delivers
        IRWrite = rdy;
        PCWrite = rdy;
        nextState = rdy ? DECODE : FETCH;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Instruction_op)
          6'b000000: nextState = EXECUTE;
          6'b100011, 6'b101011: nextState = MEMADR;
          6'b000100: nextState = BRANCH;
          6'b001000: nextState = ENABLE_ADDI ? ADDIEX : ILLEGAL;
          6'b000010: nextState = ENABLE_JUMP ? JUMP : ILLEGAL;
          default: nextState = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nextState = (Instruction_op == 6'b100011) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD = 1'b1;
        nextState = rdy ? MEMWB : MEMRD;
      end
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        nextState = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD = 1'b1;
        nextState = rdy ? FETCH : MEMWR;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b10;
        nextState = ALUWB;
      end
      ALUWB: begin
        RegDst = 1'b1;
        RegWrite = 1'b1;
        nextState = FETCH;
      end
      BRANCH: begin
        ALUSrcA = 1'b1;
        ALUOp = 2'b01;
        Branch = 1'b1;
        PCSrc = 2'b01;
        nextState = FETCH;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        nextState = ADDIWB;
      end
      ADDIWB: begin
        RegWrite = 1'b1;
        nextState = FETCH;
      end
      JUMP: begin
        PCWrite = 1'b1;
        PCSrc = 2'b10;
        nextState = FETCH;
      end
      ILLEGAL: begin
        IllegalOp = 1'b1;
        nextState = FETCH;
      end
      default: nextState = IDLE;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: scoreboard bench for two parameterisations of the control unit.
module tb_multicycle_control_unit;
  // expected output vector: {PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
  // RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSrc[1:0], IllegalOp}
  localparam logic [16:0] E_IDLE   = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_FETCH  = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_FSTALL = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
  localparam logic [16:0] E_DECODE = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
  localparam logic [16:0] E_MEMADR = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_MEMRD  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_MEMWB  = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
  localparam logic [16:0] E_MEMWR  = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
  localparam logic [16:0] E_EXEC   = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
  localparam logic [16:0] E_ALUWB  = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
  localparam logic [16:0] E_BRANCH = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
  localparam logic [16:0] E_ADDIEX = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
  localparam logic [16:0] E_ADDIWB = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;
  localparam logic [16:0] E_JUMP   = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
  localparam logic [16:0] E_ILL    = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_1;
  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_ADDI = 6'b001000, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0][5:0] op = '0;
  logic [1:0] rdy = 2'b11;
  logic [1:0] pcw, br, iord, mrd, mwr, irw, m2r, rdst, rw, asa, ill;
  logic [1:0][1:0] asb, aop, psrc;
  logic [1:0][3:0] st;
  logic [20:0] q0[$];
  logic [20:0] q1[$];
  int total = 0;
  int passed = 0;
  always #5 clk = ~clk;
  multicycle_control_unit dut0 (
    .clk(clk), .rst_n(rst_n), .Instruction_op(op[0]), .MemReady(rdy[0]),
    .PCWrite(pcw[0]), .Branch(br[0]), .IorD(iord[0]), .MemRead(mrd[0]), .MemWrite(mwr[0]),
    .IRWrite(irw[0]), .MemtoReg(m2r[0]), .RegDst(rdst[0]), .RegWrite(rw[0]), .ALUSrcA(asa[0]),
    .ALUSrcB(asb[0]), .ALUOp(aop[0]), .PCSrc(psrc[0]), .IllegalOp(ill[0]), .State(st[0])
  );
  multicycle_control_unit #(.MEM_WAIT(1'b0), .ENABLE_ADDI(1'b0), .ENABLE_JUMP(1'b0)) dut1 (
    .clk(clk), .rst_n(rst_n), .Instruction_op(op[1]), .MemReady(rdy[1]),
    .PCWrite(pcw[1]), .Branch(br[1]), .IorD(iord[1]), .MemRead(mrd[1]), .MemWrite(mwr[1]),
    .IRWrite(irw[1]), .MemtoReg(m2r[1]), .RegDst(rdst[1]), .RegWrite(rw[1]), .ALUSrcA(asa[1]),
    .ALUSrcB(asb[1]), .ALUOp(aop[1]), .PCSrc(psrc[1]), .IllegalOp(ill[1]), .State(st[1])
  );
  function automatic logic [20:0] got(input int d);
    return {st[d], pcw[d], br[d], iord[d], mrd[d], mwr[d], irw[d], m2r[d], rdst[d], rw[d],
            asa[d], asb[d], aop[d], psrc[d], ill[d]};
  endfunction
  task automatic chk(input int d, input logic [20:0] e);
    logic [20:0] g;
    g = got(d);
    total++;
    if (g === e) passed++;
    else $display("FAIL dut%0d check %0d: got state=%0d outs=%b, expected state=%0d outs=%b",
                  d, total, g[20:17], g[16:0], e[20:17], e[16:0]);
  endtask
  // monitor: the DUT presents a fresh control word every cycle; compare mid-cycle
  always @(negedge clk) begin
    if (q0.size() > 0) chk(0, q0.pop_front());
    if (q1.size() > 0) chk(1, q1.pop_front());
  end
  task automatic push(input int d, input logic [3:0] s, input logic [16:0] o);
    if (d == 0) q0.push_back({s, o});
    else q1.push_back({s, o});
  endtask
  task automatic cyc(input int d, input logic [5:0] o, input logic r, input logic [3:0] s,
                     input logic [16:0] e);
    @(posedge clk);
    #1;
    op[d] = o;
    rdy[d] = r;
    push(d, s, e);
  endtask
  task automatic release_reset(input int d);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push(d, 4'd0, E_IDLE);
  endtask
  initial begin
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1 push(0, 4'd0, E_IDLE);
    release_reset(0);
    // R-format
    cyc(0, OP_R, 1, 1, E_FETCH); cyc(0, OP_R, 1, 2, E_DECODE);
    cyc(0, OP_R, 1, 7, E_EXEC); cyc(0, OP_R, 1, 8, E_ALUWB);
    // lw with two MEMRD wait states
    cyc(0, OP_LW, 1, 1, E_FETCH); cyc(0, OP_LW, 0, 2, E_DECODE); cyc(0, OP_LW, 1, 3, E_MEMADR);
    cyc(0, OP_LW, 0, 4, E_MEMRD); cyc(0, OP_LW, 0, 4, E_MEMRD); cyc(0, OP_LW, 1, 4, E_MEMRD);
    cyc(0, OP_LW, 1, 5, E_MEMWB);
    // sw, beq, j
    cyc(0, OP_SW, 1, 1, E_FETCH); cyc(0, OP_SW, 1, 2, E_DECODE); cyc(0, OP_SW, 1, 3, E_MEMADR);
    cyc(0, OP_SW, 1, 6, E_MEMWR);
    cyc(0, OP_BEQ, 1, 1, E_FETCH); cyc(0, OP_BEQ, 0, 2, E_DECODE); cyc(0, OP_BEQ, 0, 9, E_BRANCH);
    cyc(0, OP_J, 1, 1, E_FETCH); cyc(0, OP_J, 1, 2, E_DECODE); cyc(0, OP_J, 1, 12, E_JUMP);
    // fetch stall of three cycles
    cyc(0, OP_R, 0, 1, E_FSTALL); cyc(0, OP_R, 0, 1, E_FSTALL); cyc(0, OP_R, 0, 1, E_FSTALL);
    cyc(0, OP_R, 1, 1, E_FETCH); cyc(0, OP_R, 1, 2, E_DECODE);
    cyc(0, OP_R, 1, 7, E_EXEC); cyc(0, OP_R, 1, 8, E_ALUWB);
    // illegal opcode, then addi enabled
    cyc(0, OP_BAD, 1, 1, E_FETCH); cyc(0, OP_BAD, 1, 2, E_DECODE); cyc(0, OP_BAD, 1, 13, E_ILL);
    cyc(0, OP_ADDI, 1, 1, E_FETCH); cyc(0, OP_ADDI, 1, 2, E_DECODE);
    cyc(0, OP_ADDI, 1, 10, E_ADDIEX); cyc(0, OP_ADDI, 1, 11, E_ADDIWB);
    // asynchronous reset while MEMWR is stalled
    cyc(0, OP_SW, 1, 1, E_FETCH); cyc(0, OP_SW, 1, 2, E_DECODE); cyc(0, OP_SW, 1, 3, E_MEMADR);
    cyc(0, OP_SW, 0, 6, E_MEMWR);
    @(posedge clk);
    #2 rst_n = 1'b0;
    push(0, 4'd0, E_IDLE);
    release_reset(0);
    cyc(0, OP_R, 1, 1, E_FETCH); cyc(0, OP_R, 1, 2, E_DECODE);
    cyc(0, OP_R, 1, 7, E_EXEC); cyc(0, OP_R, 1, 8, E_ALUWB);
    // second instance: no wait states, addi and j disabled
    @(posedge clk);
    #1 rst_n = 1'b0;
    op[1] = OP_R;
    release_reset(1);
    cyc(1, OP_R, 0, 1, E_FETCH); cyc(1, OP_R, 0, 2, E_DECODE);
    cyc(1, OP_R, 0, 7, E_EXEC); cyc(1, OP_R, 0, 8, E_ALUWB);
    cyc(1, OP_LW, 0, 1, E_FETCH); cyc(1, OP_LW, 0, 2, E_DECODE); cyc(1, OP_LW, 0, 3, E_MEMADR);
    cyc(1, OP_LW, 0, 4, E_MEMRD); cyc(1, OP_LW, 0, 5, E_MEMWB);
    cyc(1, OP_ADDI, 1, 1, E_FETCH); cyc(1, OP_ADDI, 1, 2, E_DECODE); cyc(1, OP_ADDI, 1, 13, E_ILL);
    cyc(1, OP_J, 1, 1, E_FETCH); cyc(1, OP_J, 1, 2, E_DECODE); cyc(1, OP_J, 1, 13, E_ILL);
    cyc(1, OP_R, 1, 1, E_FETCH);
    @(negedge clk);
    #1;
    if (q0.size() + q1.size() != 0) begin
      total++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q0.size() + q1.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
